// File: rtl/mips_pipe_cpu.sv
// Five-stage pipelined MIPS core for a reduced integer ISA, with instruction memory,
// register file and data memory inside; EX/MEM then MEM/WB forwarding, load-use stall, EX-stage redirect.

module mips_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] next_i,
  output logic [31:0] pc_o
);
  logic [31:0] PC;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      PC <= RESET_PC;
    else if (en_i) PC <= next_i;
  end

  assign pc_o = PC;
endmodule

module mips_imem #(
  parameter int IMEM_WORDS = 1024,
  parameter int AW         = 10
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);
  logic [31:0] imem [0:IMEM_WORDS-1];

  assign instr_o = imem[addr_i];
endmodule

module mips_pipe_cpu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    link;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  dest, rs, rt, shamt;
    logic [31:0] rs_val, rt_val, ext, target, pc4;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write, mem_read, mem_write;
    logic [4:0]  dest;
    logic [31:0] alu, store;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
  } mem_wb_t;

  logic [31:0] pc, pc4, Instr;
  logic        stall, redirect, taken, wb_we;
  logic [31:0] if_id_instr_q, if_id_pc4_q;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_dest;
  logic [15:0] id_imm;
  logic [31:0] id_ext, id_target, id_rs_val, id_rt_val;
  logic        id_use_rs, id_use_rt;
  ctrl_t       id_ctrl;
  id_ex_t      id_ex_d, id_ex_q;
  ex_mem_t     ex_mem_d, ex_mem_q;
  mem_wb_t     mem_wb_d, mem_wb_q;
  logic [31:0] fwd_a, fwd_b, op_b, alu;
  logic [31:0] gpr_q  [0:31];
  logic [31:0] dmem_q [0:DMEM_WORDS-1];

  // ---------------- IF ----------------
  mips_pc #(.RESET_PC(RESET_PC)) U_PC (
    .clk(clk), .rst(rst), .en_i(redirect || !stall),
    .next_i(redirect ? id_ex_q.target : pc4), .pc_o(pc)
  );

  mips_imem #(.IMEM_WORDS(IMEM_WORDS), .AW(IAW)) U_IM (
    .addr_i(pc[IAW+1:2]), .instr_o(Instr)
  );

  assign pc4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || redirect) begin
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
    end else if (!stall) begin
      if_id_instr_q <= Instr;
      if_id_pc4_q   <= pc4;
    end
  end

  // ---------------- ID ----------------
  assign id_op    = if_id_instr_q[31:26];
  assign id_rs    = if_id_instr_q[25:21];
  assign id_rt    = if_id_instr_q[20:16];
  assign id_rd    = if_id_instr_q[15:11];
  assign id_shamt = if_id_instr_q[10:6];
  assign id_funct = if_id_instr_q[5:0];
  assign id_imm   = if_id_instr_q[15:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    id_ctrl   = '0;
    id_dest   = id_rt;
    id_ext    = {{16{id_imm[15]}}, id_imm};
    id_use_rs = 1'b1;
    id_use_rt = 1'b0;
    case (id_op)
      6'h00: begin
        id_dest           = id_rd;
        id_use_rt         = 1'b1;
        id_ctrl.reg_write = 1'b1;
        case (id_funct)
          6'h21:   id_ctrl.alu_op = ALU_ADD;
          6'h23:   id_ctrl.alu_op = ALU_SUB;
          6'h24:   id_ctrl.alu_op = ALU_AND;
          6'h25:   id_ctrl.alu_op = ALU_OR;
          6'h2a:   id_ctrl.alu_op = ALU_SLT;
          6'h00: begin id_ctrl.alu_op = ALU_SLL; id_use_rs = 1'b0; end
          default: id_ctrl.reg_write = 1'b0;
        endcase
      end
      6'h0d: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.alu_op = ALU_OR;  id_ext = {16'h0, id_imm}; end
      6'h0c: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.alu_op = ALU_AND; id_ext = {16'h0, id_imm}; end
      6'h09: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.alu_op = ALU_ADD; end
      6'h0f: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.alu_op = ALU_LUI; id_use_rs = 1'b0; end
      6'h23: begin id_ctrl.reg_write = 1'b1; id_ctrl.mem_read = 1'b1; id_ctrl.alu_src = 1'b1; end
      6'h2b: begin id_ctrl.mem_write = 1'b1; id_ctrl.alu_src = 1'b1; id_use_rt = 1'b1; end
      6'h04: begin id_ctrl.beq = 1'b1; id_use_rt = 1'b1; end
      6'h05: begin id_ctrl.bne = 1'b1; id_use_rt = 1'b1; end
      6'h02: begin id_ctrl.jump = 1'b1; id_use_rs = 1'b0; end
      6'h03: begin
        id_ctrl.jump = 1'b1; id_ctrl.link = 1'b1; id_ctrl.reg_write = 1'b1;
        id_dest = 5'd31; id_use_rs = 1'b0;
      end
      default: id_use_rs = 1'b0;
    endcase
  end

  assign id_target = id_ctrl.jump ? {if_id_pc4_q[31:28], if_id_instr_q[25:0], 2'b00}
                                  : if_id_pc4_q + {id_ext[29:0], 2'b00};

  // Register file read with same-cycle WB bypass.
  assign wb_we     = mem_wb_q.reg_write && (mem_wb_q.dest != 5'd0);
  assign id_rs_val = (id_rs == 5'd0) ? '0 : (wb_we && mem_wb_q.dest == id_rs) ? mem_wb_q.data : gpr_q[id_rs];
  assign id_rt_val = (id_rt == 5'd0) ? '0 : (wb_we && mem_wb_q.dest == id_rt) ? mem_wb_q.data : gpr_q[id_rt];

  assign stall = id_ex_q.ctrl.mem_read && (id_ex_q.dest != 5'd0) &&
                 ((id_use_rs && id_ex_q.dest == id_rs) || (id_use_rt && id_ex_q.dest == id_rt));

  always_comb begin
    id_ex_d = '0;
    if (!redirect && !stall) begin
      id_ex_d.ctrl   = id_ctrl;
      id_ex_d.dest   = id_dest;
      id_ex_d.rs     = id_rs;
      id_ex_d.rt     = id_rt;
      id_ex_d.shamt  = id_shamt;
      id_ex_d.rs_val = id_rs_val;
      id_ex_d.rt_val = id_rt_val;
      id_ex_d.ext    = id_ext;
      id_ex_d.target = id_target;
      id_ex_d.pc4    = if_id_pc4_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) id_ex_q <= '0;
    else      id_ex_q <= id_ex_d;
  end

  // ---------------- EX ----------------
  always_comb begin
    fwd_a = id_ex_q.rs_val;
    fwd_b = id_ex_q.rt_val;
    if (ex_mem_q.reg_write && ex_mem_q.dest != 5'd0 && ex_mem_q.dest == id_ex_q.rs) fwd_a = ex_mem_q.alu;
    else if (wb_we && mem_wb_q.dest == id_ex_q.rs)                                   fwd_a = mem_wb_q.data;
    if (ex_mem_q.reg_write && ex_mem_q.dest != 5'd0 && ex_mem_q.dest == id_ex_q.rt) fwd_b = ex_mem_q.alu;
    else if (wb_we && mem_wb_q.dest == id_ex_q.rt)                                   fwd_b = mem_wb_q.data;
  end

  assign op_b = id_ex_q.ctrl.alu_src ? id_ex_q.ext : fwd_b;

  always_comb begin
    alu = '0;
    case (id_ex_q.ctrl.alu_op)
      ALU_ADD: alu = fwd_a + op_b;
      ALU_SUB: alu = fwd_a - op_b;
      ALU_AND: alu = fwd_a & op_b;
      ALU_OR:  alu = fwd_a | op_b;
      ALU_SLT: alu = {31'b0, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLL: alu = op_b << id_ex_q.shamt;
      ALU_LUI: alu = {op_b[15:0], 16'h0};
      default: alu = '0;
    endcase
  end

  assign taken    = (id_ex_q.ctrl.beq && fwd_a == fwd_b) || (id_ex_q.ctrl.bne && fwd_a != fwd_b);
  assign redirect = taken || id_ex_q.ctrl.jump;

  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.reg_write = id_ex_q.ctrl.reg_write;
    ex_mem_d.mem_read  = id_ex_q.ctrl.mem_read;
    ex_mem_d.mem_write = id_ex_q.ctrl.mem_write;
    ex_mem_d.dest      = id_ex_q.dest;
    ex_mem_d.alu       = id_ex_q.ctrl.link ? id_ex_q.pc4 : alu;
    ex_mem_d.store     = fwd_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_mem_q <= '0;
    else      ex_mem_q <= ex_mem_d;
  end

  // ---------------- MEM / WB ----------------
  always_comb begin
    mem_wb_d           = '0;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.dest      = ex_mem_q.dest;
    mem_wb_d.data      = ex_mem_q.mem_read ? dmem_q[ex_mem_q.alu[DAW+1:2]] : ex_mem_q.alu;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_wb_q <= '0;
    else      mem_wb_q <= mem_wb_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (ex_mem_q.mem_write) begin
      dmem_q[ex_mem_q.alu[DAW+1:2]] <= ex_mem_q.store;
    end
  end

  // NOTE: this array is architecturally zeroed on reset, so it must be flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (wb_we) begin
      gpr_q[mem_wb_q.dest] <= mem_wb_q.data;
    end
  end
endmodule

// File: tb/tb_mips_pipe_cpu.sv
// Directed bench for mips_pipe_cpu: preloads a short program, then checks fetch PC
// sequence, forwarding, load-use stall, branch/jal flushes and asynchronous reset.

module tb_mips_pipe_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;

  mips_pipe_cpu dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to rising edge k after reset release, then sample on the following falling edge.
  task automatic run_to(input int k);
    repeat (k - edge_cnt) @(posedge clk);
    edge_cnt = k;
    @(negedge clk);
  endtask

  logic [31:0] prog [0:16];

  initial begin
    prog = '{32'h3401_0005,   // 3000 ori  $1,$0,5
             32'h3402_0007,   // 3004 ori  $2,$0,7
             32'h0022_1821,   // 3008 addu $3,$1,$2
             32'hAC03_0000,   // 300C sw   $3,0($0)
             32'h8C04_0000,   // 3010 lw   $4,0($0)
             32'h0084_2821,   // 3014 addu $5,$4,$4
             32'h1021_0002,   // 3018 beq  $1,$1,+2 -> 3024
             32'h3406_0001,   // 301C ori  $6 (flushed)
             32'h3407_0001,   // 3020 ori  $7 (flushed)
             32'h0C00_0C10,   // 3024 jal  0x3040
             32'h3408_0001,   // 3028 ori  $8 (flushed)
             32'h3409_0001,   // 302C ori  $9 (flushed)
             32'h0, 32'h0, 32'h0, 32'h0,
             32'h340A_0055};  // 3040 ori  $10,$0,0x55
    for (int i = 0; i < 1024; i++) dut.U_IM.imem[i] = 32'h0;
    for (int i = 0; i < 17; i++)   dut.U_IM.imem[i] = prog[i];

    #22;
    check("rst_pc",    dut.U_PC.PC,    32'h0000_3000);
    check("rst_gpr1",  dut.gpr_q[1],   32'h0);
    check("rst_dmem0", dut.dmem_q[0],  32'h0);

    @(negedge clk);
    rst = 1'b1;
    edge_cnt = 0;
    check("rel_pc",    dut.U_PC.PC, 32'h0000_3000);
    check("rel_instr", dut.Instr,   32'h3401_0005);
    run_to(1);  check("pc_e1", dut.U_PC.PC, 32'h0000_3004);
    run_to(2);  check("pc_e2", dut.U_PC.PC, 32'h0000_3008);
    run_to(6);  check("pc_e6",       dut.U_PC.PC,   32'h0000_3018);
    check("dmem0_before_sw",          dut.dmem_q[0], 32'h0);
    run_to(7);  check("pc_e7_stall", dut.U_PC.PC,   32'h0000_3018);
    check("fwd_addu_r3",              dut.gpr_q[3],  32'd12);
    check("sw_dmem0",                 dut.dmem_q[0], 32'd12);
    run_to(8);  check("pc_e8",  dut.U_PC.PC, 32'h0000_301C);
    run_to(9);  check("pc_e9",  dut.U_PC.PC, 32'h0000_3020);
    run_to(10); check("beq_target_pc", dut.U_PC.PC, 32'h0000_3024);
    run_to(11); check("pc_e11",        dut.U_PC.PC, 32'h0000_3028);
    check("loaduse_r5",                dut.gpr_q[5], 32'd24);
    run_to(12); check("pc_e12",        dut.U_PC.PC, 32'h0000_302C);
    run_to(13); check("jal_target_pc", dut.U_PC.PC, 32'h0000_3040);
    run_to(14); check("pc_e14",        dut.U_PC.PC, 32'h0000_3044);

    run_to(25);
    check("r0",  dut.gpr_q[0],  32'h0);
    check("r1",  dut.gpr_q[1],  32'd5);
    check("r2",  dut.gpr_q[2],  32'd7);
    check("r4",  dut.gpr_q[4],  32'd12);
    check("r6_flushed", dut.gpr_q[6], 32'h0);
    check("r7_flushed", dut.gpr_q[7], 32'h0);
    check("r8_flushed", dut.gpr_q[8], 32'h0);
    check("r9_flushed", dut.gpr_q[9], 32'h0);
    check("r31_link",   dut.gpr_q[31], 32'h0000_3028);
    check("r10_target", dut.gpr_q[10], 32'h0000_0055);

    // Asynchronous reset asserted between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_pc",    dut.U_PC.PC,   32'h0000_3000);
    check("async_r3",    dut.gpr_q[3],  32'h0);
    check("async_r31",   dut.gpr_q[31], 32'h0);
    check("async_dmem0", dut.dmem_q[0], 32'h0);

    @(negedge clk);
    rst = 1'b1;
    edge_cnt = 0;
    run_to(1);  check("restart_pc_e1",  dut.U_PC.PC, 32'h0000_3004);
    run_to(7);  check("restart_pc_e7",  dut.U_PC.PC, 32'h0000_3018);
    run_to(10); check("restart_pc_e10", dut.U_PC.PC, 32'h0000_3024);
    run_to(11); check("restart_r5",     dut.gpr_q[5], 32'd24);
    check("restart_r3",                 dut.gpr_q[3], 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
